// File: rtl/spi_transmitter_if.sv
// Parallel word handshake and 3-wire serial link of the SPI transmitter.
// The DUT uses the slave side. The upstream driver uses the master side.
interface spi_transmitter_if;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        s_clk;
    logic        cs;
    logic        mosi;
    logic [1:0]  state;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, s_clk, cs, mosi, state
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, s_clk, cs, mosi, state
    );
endinterface

// File: rtl/spi_transmitter.sv
// Sends 16-bit words MSB first over s_clk/cs/mosi with a free-running s_clk.
// cs and mosi only change on s_clk falling toggles, so they are stable at every rising edge.
module spi_transmitter #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 2
) (
    input logic               clk,
    input logic               reset,
    spi_transmitter_if.slave  bus
);
    // Handshake: a word is accepted when tx_valid && tx_ready at a rising clk edge.
    // tx_data is sampled only on that edge. tx_ready stays low until the gap after the frame has elapsed.
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int GW = $clog2(CS_IDLE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic            s_clk_q;
    logic            cs_q;
    logic            mosi_q;
    logic            tx_ready_q;
    logic            busy_q;
    logic [15:0]     shreg;
    logic [4:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;

    logic div_wrap;
    logic rise_evt;
    logic fall_evt;

    assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
    assign rise_evt = div_wrap && !s_clk_q;
    assign fall_evt = div_wrap && s_clk_q;

    assign bus.s_clk    = s_clk_q;
    assign bus.cs       = cs_q;
    assign bus.mosi     = mosi_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
    assign bus.state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            s_clk_q    <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= GW'(CS_IDLE);
        end else begin
            if (div_wrap) begin
                div_cnt <= '0;
                s_clk_q <= ~s_clk_q;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        shreg      <= bus.tx_data;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ARM;
                    end else begin
                        tx_ready_q <= (gap_cnt >= GW'(CS_IDLE));
                    end
                end

                // Waiting here even when the accept edge was itself a fall event keeps the first bit's setup time.
                ARM: begin
                    if (fall_evt) begin
                        cs_q    <= 1'b0;
                        mosi_q  <= shreg[15];
                        shreg   <= {shreg[14:0], 1'b0};
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (rise_evt) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (fall_evt) begin
                        if (bit_cnt == 5'd16) begin
                            cs_q    <= 1'b1;
                            mosi_q  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            mosi_q <= shreg[15];
                            shreg  <= {shreg[14:0], 1'b0};
                        end
                    end
                end

                GAP: begin
                    if (rise_evt) begin
                        if (gap_cnt >= GW'(CS_IDLE - 1)) begin
                            gap_cnt    <= GW'(CS_IDLE);
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_transmitter.sv
// Directed bench for spi_transmitter: receiver models feed a scoreboard of expected words.
// Two instances cover CLK_DIV=4 and CLK_DIV=1.
module tb_spi_transmitter;
    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q4[$];
    logic [15:0] exp_q1[$];

    spi_transmitter_if bus4();
    spi_transmitter_if bus1();

    spi_transmitter #(.CLK_DIV(4), .CS_IDLE(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    spi_transmitter #(.CLK_DIV(1), .CS_IDLE(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Receiver model: shifts mosi on s_clk rises with cs low, clears on rises with cs high.
    int          rx_cnt4 = 0, rx_cnt1 = 0;
    int          idle4 = 0, idle1 = 0;
    bit          have_prev4 = 0, have_prev1 = 0;
    logic [15:0] rx_sr4, rx_sr1;

    always @(posedge reset) begin
        rx_cnt4 = 0; rx_cnt1 = 0;
        have_prev4 = 0; have_prev1 = 0;
    end

    always @(posedge bus4.s_clk) begin
        if (bus4.cs) begin
            rx_cnt4 = 0;
            idle4++;
        end else begin
            if (rx_cnt4 == 0 && have_prev4) check("gap_rises4", idle4 >= 2, 1);
            rx_sr4 = {rx_sr4[14:0], bus4.mosi};
            rx_cnt4++;
            if (rx_cnt4 == 16) begin
                if (exp_q4.size() == 0) check("unexpected_frame4", 1, 0);
                else check("word4", rx_sr4, exp_q4.pop_front());
                have_prev4 = 1;
                idle4 = 0;
                rx_cnt4 = 0;
            end
        end
    end

    always @(posedge bus1.s_clk) begin
        if (bus1.cs) begin
            rx_cnt1 = 0;
            idle1++;
        end else begin
            if (rx_cnt1 == 0 && have_prev1) check("gap_rises1", idle1 >= 2, 1);
            rx_sr1 = {rx_sr1[14:0], bus1.mosi};
            rx_cnt1++;
            if (rx_cnt1 == 16) begin
                if (exp_q1.size() == 0) check("unexpected_frame1", 1, 0);
                else check("word1", rx_sr1, exp_q1.pop_front());
                have_prev1 = 1;
                idle1 = 0;
                rx_cnt1 = 0;
            end
        end
    end

    // cs low duration, measured in clk cycles from falling to rising cs.
    int low4 = 0, low1 = 0;
    always @(negedge clk) begin
        if (reset) begin
            low4 = 0;
            low1 = 0;
        end else begin
            if (!bus4.cs) low4++;
            else if (low4 != 0) begin
                check("cs_low_len4", low4, 128);
                low4 = 0;
            end
            if (!bus1.cs) low1++;
            else if (low1 != 0) begin
                check("cs_low_len1", low1, 32);
                low1 = 0;
            end
        end
    end

    task automatic send(input bit sel, input logic [15:0] d, input bit keep);
        int w;
        int lat;
        @(negedge clk);
        if (sel) begin bus1.tx_data = d; bus1.tx_valid = 1'b1; end
        else     begin bus4.tx_data = d; bus4.tx_valid = 1'b1; end
        w = 0;
        while (!(sel ? bus1.tx_ready : bus4.tx_ready) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", w < 3000, 1);
        @(posedge clk);
        if (sel) exp_q1.push_back(d); else exp_q4.push_back(d);
        #1;
        if (!keep) begin
            if (sel) bus1.tx_valid = 1'b0; else bus4.tx_valid = 1'b0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while ((sel ? bus1.cs : bus4.cs) && lat < 100);
        check("accept_to_cs", (lat - 1 >= 1) && (lat - 1 <= (sel ? 2 : 8)), 1);
    endtask

    task automatic wait_idle(input bit sel);
        int w;
        w = 0;
        while (w < 3000 && ((sel ? bus1.busy : bus4.busy) ||
               (sel ? exp_q1.size() : exp_q4.size()) != 0)) begin
            @(negedge clk);
            w++;
        end
        check("idle_timeout", w < 3000, 1);
        check("ready_with_busy_low", sel ? bus1.tx_ready : bus4.tx_ready, 1);
    endtask

    initial begin
        int n;
        int w;
        bit seen_ready;

        bus4.tx_valid = 1'b0; bus4.tx_data = '0;
        bus1.tx_valid = 1'b0; bus1.tx_data = '0;
        reset = 1'b1;
        #1;
        check("rst_cs", bus4.cs, 1);
        check("rst_sclk", bus4.s_clk, 0);
        check("rst_mosi", bus4.mosi, 0);
        check("rst_ready", bus4.tx_ready, 0);
        check("rst_busy", bus4.busy, 0);
        check("rst_state", bus4.state, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_before_edge", bus4.tx_ready, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("ready_after_release", bus4.tx_ready, 1);
                check("first_rise1", bus1.s_clk, 1);
            end
        end while (!bus4.s_clk && n < 50);
        check("first_rise4_edges", n, 4);

        // Single word
        send(0, 16'hA5C3, 0);
        wait_idle(0);

        // Back-to-back with tx_valid held high
        send(0, 16'hFFFF, 1);
        send(0, 16'h0001, 0);
        wait_idle(0);

        // Inputs disturbed mid-frame must not affect the word or tx_ready
        send(0, 16'h1234, 0);
        seen_ready = 0;
        w = 0;
        while (!bus4.cs && w < 1000) begin
            bus4.tx_valid = 1'($urandom_range(0, 1));
            bus4.tx_data  = 16'h0000;
            @(negedge clk);
            if (bus4.tx_ready) seen_ready = 1;
            w++;
        end
        bus4.tx_valid = 1'b0;
        check("ready_low_in_frame", seen_ready, 0);
        wait_idle(0);

        // Reset after 7 bits of 0xBEEF
        send(0, 16'hBEEF, 0);
        w = 0;
        while (rx_cnt4 < 7 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("reach_bit7", rx_cnt4, 7);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cs", bus4.cs, 1);
        check("midrst_sclk", bus4.s_clk, 0);
        check("midrst_mosi", bus4.mosi, 0);
        check("midrst_ready", bus4.tx_ready, 0);
        check("midrst_busy", bus4.busy, 0);
        exp_q4.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", bus4.tx_ready, 1);
        send(0, 16'h1234, 0);
        wait_idle(0);

        // CLK_DIV=1 instance
        send(1, 16'h8001, 0);
        wait_idle(1);
        send(1, 16'h5AA5, 0);
        wait_idle(1);

        repeat (4) @(negedge clk);
        check("q4_drained", exp_q4.size(), 0);
        check("q1_drained", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
